// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: segmented-carry pipelined adder/subtractor.
// Define PIPE_ADD_FLAGS_EN to build the overflow/zero/lt flags.
module pipelined_add_sub #(
  parameter int N     = 32,
  parameter int SEG_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         lt
);

  localparam int STAGES = N / SEG_W;
  localparam int L      = STAGES - 1;

  // c is carry-in on the input side, carry-out once registered
  typedef struct packed {
    logic         v;
    logic         c;
    logic [N-1:0] s;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef PIPE_ADD_FLAGS_EN
    logic         sa;
    logic         sb;
    logic         sub;
`endif
  } stg_t;

  stg_t           in_s [STAGES];
  stg_t           nx_s [STAGES];
  stg_t           st_q [STAGES];
  logic [SEG_W:0] seg  [STAGES];
  logic           advance;

  assign advance  = !st_q[L].v || out_ready;
  assign in_ready = advance;

  always_comb begin
    in_s[0]   = '0;
    in_s[0].v = in_valid;
    in_s[0].c = sub | cin;
    in_s[0].a = a;
    in_s[0].b = sub ? ~b : b;
`ifdef PIPE_ADD_FLAGS_EN
    in_s[0].sa  = a[N-1];
    in_s[0].sb  = in_s[0].b[N-1];
    in_s[0].sub = sub;
`endif
    for (int k = 1; k < STAGES; k++) begin
      in_s[k] = st_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg[k] = {1'b0, in_s[k].a[k*SEG_W +: SEG_W]}
             + {1'b0, in_s[k].b[k*SEG_W +: SEG_W]}
             + (SEG_W+1)'(in_s[k].c);
      nx_s[k] = in_s[k];
      nx_s[k].s[k*SEG_W +: SEG_W] = seg[k][SEG_W-1:0];
      nx_s[k].c = seg[k][SEG_W];
    end
  end

  // bubbles only clear the valid bit so idle outputs stay quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (in_s[k].v) begin
          st_q[k] <= nx_s[k];
        end else begin
          st_q[k].v <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st_q[L].v;
  assign sum       = st_q[L].s;
  assign cout      = st_q[L].c;

`ifdef PIPE_ADD_FLAGS_EN
  logic ov_n;
  logic ov_q;
  logic z_q;
  logic lt_q;

  always_comb begin
    ov_n = (in_s[L].sa == in_s[L].sb)
        && (nx_s[L].s[N-1] != in_s[L].sa);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      z_q  <= 1'b0;
      lt_q <= 1'b0;
    end else if (advance && in_s[L].v) begin
      ov_q <= ov_n;
      z_q  <= (nx_s[L].s == '0);
      lt_q <= in_s[L].sub & (nx_s[L].s[N-1] ^ ov_n);
    end
  end

  assign overflow = ov_q;
  assign zero     = z_q;
  assign lt       = lt_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign lt       = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed + random checks against an arithmetic model.
// Honours PIPE_ADD_FLAGS_EN for the expected flag values.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv, ir, ci, sb, ov, ordy, co, fo, fz, fl;
  logic [31:0] a32, b32, s32;
  logic        iv16, ir16, ci16, sb16, ov16, ordy16;
  logic        co16, fo16, fz16, fl16;
  logic [15:0] a16, b16, s16;

  pipelined_add_sub #(.N(32), .SEG_W(8)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .a(a32), .b(b32), .cin(ci), .sub(sb),
    .out_valid(ov), .out_ready(ordy),
    .sum(s32), .cout(co),
    .overflow(fo), .zero(fz), .lt(fl)
  );

  pipelined_add_sub #(.N(16), .SEG_W(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(ci16), .sub(sb16),
    .out_valid(ov16), .out_ready(ordy16),
    .sum(s16), .cout(co16),
    .overflow(fo16), .zero(fz16), .lt(fl16)
  );

`ifdef PIPE_ADD_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        lt;
  } res_t;

  int   passed;
  int   total;
  int   delivered;
  res_t q[$];

  // exact signed/unsigned arithmetic on w-bit operands
  function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                 logic cin, logic sub, int w);
    longint m, ua, ub, full, sa, sbv, ex, lim;
    res_t   r;
    m    = (longint'(1) << w) - 1;
    ua   = {32'd0, a} & m;
    ub   = {32'd0, b} & m;
    full = sub ? ua + (~ub & m) + 1 : ua + ub + longint'(cin);
    r      = '0;
    r.sum  = 32'(full & m);
    r.cout = ((full >> w) & 1) != 0;
    lim  = longint'(1) << (w - 1);
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sbv  = (ub >= lim) ? ub - 2 * lim : ub;
    ex   = sub ? sa - sbv : sa + sbv + longint'(cin);
    if (FLAGS) begin
      r.ovf  = (ex >= lim) || (ex < -lim);
      r.zero = (r.sum == 0);
      r.lt   = sub && (sa < sbv);
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic settle();
    #1;
  endtask

  // one clock of the 32-bit unit with scoreboard bookkeeping
  task automatic cyc();
    res_t e;
    res_t h;
    logic hold;
    #1;
    if (ov && ordy) begin
      chk("not_spurious", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", s32, e.sum);
        chk("cout", co, e.cout);
        chk("overflow", fo, e.ovf);
        chk("zero", fz, e.zero);
        chk("lt", fl, e.lt);
        delivered++;
      end
    end
    if (iv && ir) q.push_back(model(a32, b32, ci, sb, 32));
    hold = ov && !ordy;
    h = {s32, co, fo, fz, fl};
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", ov, 1);
      chk("hold_data", {s32, co, fo, fz, fl}, h);
    end
  endtask

  // send one beat, wait for the result; leaves it presented
  task automatic one(logic [31:0] a, logic [31:0] b, logic c, logic s);
    int n;
    a32 = a; b32 = b; ci = c; sb = s;
    iv = 1'b1; ordy = 1'b1;
    settle();
    chk("accept_ready", ir, 1);
    cyc();
    iv = 1'b0;
    n = 1;
    while (!ov && n < 20) begin
      cyc();
      n++;
    end
    chk("latency", n, 4);
  endtask

  task automatic u16op(logic [15:0] a, logic [15:0] b, logic c, logic s);
    res_t e;
    a16 = a; b16 = b; ci16 = c; sb16 = s;
    iv16 = 1'b1; ordy16 = 1'b1;
    e = model({16'd0, a}, {16'd0, b}, c, s, 16);
    settle();
    chk("u16_ready", ir16, 1);
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    chk("u16_valid", ov16, 1);
    chk("u16_sum", s16, e.sum[15:0]);
    chk("u16_cout", co16, e.cout);
    chk("u16_ovf", fo16, e.ovf);
    chk("u16_zero", fz16, e.zero);
    chk("u16_lt", fl16, e.lt);
    @(posedge clk);
    @(negedge clk);
    chk("u16_drain", ov16, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i, stl, seen, n;
    logic stuck;
    passed = 0; total = 0; delivered = 0;
    rst = 1'b1;
    iv = 0; ordy = 1; a32 = 0; b32 = 0; ci = 0; sb = 0;
    iv16 = 0; ordy16 = 1; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("rst_valid", ov, 0);
    chk("rst_sum", s32, 0);
    chk("rst_cout", co, 0);
    chk("rst_flags", {fo, fz, fl}, 0);
    chk("rst_ready", ir, 1);
    chk("rst16_valid", ov16, 0);
    chk("rst16_ready", ir16, 1);

    one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("wrap_sum", s32, 0);
    chk("wrap_cout", co, 1);
    cyc();
    one(32'd5, 32'd7, 1'b0, 1'b1);
    chk("sub57_sum", s32, 32'hFFFF_FFFE);
    chk("sub57_cout", co, 0);
    cyc();
    one(32'd7, 32'd5, 1'b0, 1'b1);
    chk("sub75_sum", s32, 32'h2);
    cyc();
    one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("ovf_add_sum", s32, 32'h8000_0000);
    cyc();
    one(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    chk("ovf_sub_sum", s32, 32'h7FFF_FFFF);
    cyc();

    delivered = 0; i = 0; stl = 0; seen = 0; n = 0;
    while (delivered < 8 && n < 60) begin
      iv = (i < 8);
      a32 = i; b32 = i; ci = i[0]; sb = 1'b0;
      if (ov && seen == 0) begin
        seen = 1;
        stl = 3;
      end
      ordy = (stl == 0);
      settle();
      if (stl > 0) begin
        chk("stall_in_ready", ir, 0);
        stl--;
      end
      if (iv && ir) i++;
      cyc();
      n++;
    end
    iv = 1'b0; ordy = 1'b1;
    chk("stall_delivered", delivered, 8);
    chk("stall_drained", q.size(), 0);

    a32 = 32'h11; b32 = 32'h22; ci = 0; sb = 0;
    iv = 1'b1; ordy = 1'b1;
    cyc();
    a32 = 32'h33;
    cyc();
    iv = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    settle();
    chk("midrst_ready", ir, 1);
    chk("midrst_out", {ov, s32, co, fo, fz, fl}, 0);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("midrst_no_valid", ov, 0);
      cyc();
    end

    stuck = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!stuck) begin
        iv  = ($urandom_range(3) != 0);
        a32 = $urandom;
        if ($urandom_range(7) == 0) a32 = 32'h8000_0000;
        b32 = ($urandom_range(7) == 0) ? a32 : $urandom;
        ci  = 1'($urandom_range(1));
        sb  = 1'($urandom_range(1));
      end
      ordy = ($urandom_range(3) != 0);
      settle();
      stuck = iv && !ir;
      cyc();
    end
    iv = 1'b0; ordy = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("rand_drained", q.size(), 0);

    u16op(16'h8000, 16'h8000, 1'b0, 1'b0);
    chk("u16_wrap_sum", s16, 0);
    chk("u16_wrap_cout", co16, 1);
    u16op(16'd3, 16'd5, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
